reg_port_ctrl: RTL and testbench

REG_PORT_CTRL -- requirements
Module: reg_port_ctrl

---
 rtl/reg_port_ctrl.sv | 103 ++++++++++
 tb/tb_reg_port_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_port_ctrl.sv
// Operand-fetch and writeback controller sitting in front of a register bank.
// Reads take one READ cycle with writeback bypass; writebacks are registered one cycle.
module reg_port_ctrl #(
  parameter int  BITS     = 8,
  parameter int  REG_SIZE = 4,
  localparam int REG_BITS = $clog2(REG_SIZE)
) (
  input  logic                clk,
  input  logic                rst_n,
  // operand-fetch request
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [REG_BITS-1:0] req_rs_a,
  input  logic [REG_BITS-1:0] req_rs_b,
  // operand response
  output logic                op_valid,
  input  logic                op_ready,
  output logic [BITS-1:0]     op_a,
  output logic [BITS-1:0]     op_b,
  // writeback request
  input  logic                wb_valid,
  output logic                wb_ready,
  input  logic [REG_BITS-1:0] wb_addr,
  input  logic [BITS-1:0]     wb_data,
  // reg_bank ports
  output logic                rb_write_enable,
  output logic [REG_BITS-1:0] rb_write_address,
  output logic [BITS-1:0]     rb_write_data,
  output logic [REG_BITS-1:0] rb_address_a,
  output logic [REG_BITS-1:0] rb_address_b,
  input  logic [BITS-1:0]     rb_data_a,
  input  logic [BITS-1:0]     rb_data_b
);

  typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;

  state_t          state, state_next;
  logic            ready_en;
  logic            req_accept;
  logic            wb_accept;
  logic [BITS-1:0] cap_a, cap_b;

  // Handshakes stay low until the first clock edge after reset release.
  assign req_ready  = ready_en && ((state == IDLE) || ((state == HOLD) && op_ready));
  assign wb_ready   = ready_en;
  assign op_valid   = (state == HOLD);
  assign req_accept = req_valid && req_ready;
  assign wb_accept  = wb_valid && wb_ready;

  // A write landing on the same edge that ends READ must be seen by the capture.
  assign cap_a = (rb_write_enable && (rb_write_address == rb_address_a)) ? rb_write_data : rb_data_a;
  assign cap_b = (rb_write_enable && (rb_write_address == rb_address_b)) ? rb_write_data : rb_data_b;

  always_comb begin
    // NOTE: default assigned first so every path drives state_next and no latch is inferred.
    state_next = state;
    unique case (state)
      IDLE: if (req_accept) state_next = READ;
      READ: state_next = HOLD;
      HOLD: if (op_ready) state_next = req_accept ? READ : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ready_en     <= 1'b0;
      rb_address_a <= '0;
      rb_address_b <= '0;
      op_a         <= '0;
      op_b         <= '0;
    end else begin
      state    <= state_next;
      ready_en <= 1'b1;
      if (req_accept) begin
        rb_address_a <= req_rs_a;
        rb_address_b <= req_rs_b;
      end
      if (state == READ) begin
        op_a <= cap_a;
        op_b <= cap_b;
      end
    end
  end

  // One-entry writeback buffer, drained into the bank on the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_write_enable  <= 1'b0;
      rb_write_address <= '0;
      rb_write_data    <= '0;
    end else begin
      rb_write_enable <= wb_accept;
      if (wb_accept) begin
        rb_write_address <= wb_addr;
        rb_write_data    <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_reg_port_ctrl.sv
// Directed bench for reg_port_ctrl with a behavioural reg_bank and an operand scoreboard.
module tb_reg_port_ctrl;
  localparam int BITS     = 8;
  localparam int REG_SIZE = 4;
  localparam int REG_BITS = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                req_valid, req_ready;
  logic [REG_BITS-1:0] req_rs_a, req_rs_b;
  logic                op_valid, op_ready;
  logic [BITS-1:0]     op_a, op_b;
  logic                wb_valid, wb_ready;
  logic [REG_BITS-1:0] wb_addr;
  logic [BITS-1:0]     wb_data;
  logic                rb_write_enable;
  logic [REG_BITS-1:0] rb_write_address, rb_address_a, rb_address_b;
  logic [BITS-1:0]     rb_write_data, rb_data_a, rb_data_b;

  typedef struct packed {
    logic [BITS-1:0] a;
    logic [BITS-1:0] b;
  } op_t;

  op_t             sb[$];
  logic [BITS-1:0] bank [REG_SIZE] = '{8'h10, 8'h20, 8'h30, 8'h40};
  logic [BITS-1:0] mdl  [REG_SIZE] = '{8'h10, 8'h20, 8'h30, 8'h40};
  int              n_checks = 0;
  int              n_fail   = 0;
  int              lat;

  always #5 clk = ~clk;

  // Behavioural register bank: synchronous write, combinational read.
  assign rb_data_a = bank[rb_address_a];
  assign rb_data_b = bank[rb_address_b];
  always @(posedge clk) if (rb_write_enable) bank[rb_write_address] <= rb_write_data;

  reg_port_ctrl #(.BITS(BITS), .REG_SIZE(REG_SIZE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rs_a(req_rs_a), .req_rs_b(req_rs_b),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .rb_write_enable(rb_write_enable), .rb_write_address(rb_write_address),
    .rb_write_data(rb_write_data), .rb_address_a(rb_address_a), .rb_address_b(rb_address_b),
    .rb_data_a(rb_data_a), .rb_data_b(rb_data_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a request and record what it must return, given all writebacks driven so far.
  task automatic issue(input logic [REG_BITS-1:0] ra, input logic [REG_BITS-1:0] rb);
    op_t e;
    req_valid = 1'b1;
    req_rs_a  = ra;
    req_rs_b  = rb;
    e.a = mdl[ra];
    e.b = mdl[rb];
    sb.push_back(e);
  endtask

  task automatic wb(input logic [REG_BITS-1:0] addr, input logic [BITS-1:0] data, input bit track);
    wb_valid = 1'b1;
    wb_addr  = addr;
    wb_data  = data;
    if (track) mdl[addr] = data;
  endtask

  // Wait (bounded) for op_valid, then compare against the oldest expectation.
  task automatic expect_resp(input string tag, output int waited);
    op_t e;
    waited = 0;
    while (op_valid !== 1'b1 && waited < 8) begin
      tick();
      waited++;
    end
    check({tag, "_valid"}, op_valid, 1);
    check({tag, "_sb_nonempty"}, sb.size() > 0, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_op_a"}, op_a, e.a);
      check({tag, "_op_b"}, op_b, e.b);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_rs_a = '0; req_rs_b = '0;
    op_ready = 1'b0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;

    // Reset state
    #2;
    check("rst_req_ready", req_ready, 0);
    check("rst_wb_ready", wb_ready, 0);
    check("rst_op_valid", op_valid, 0);
    check("rst_op_a", op_a, 0);
    check("rst_rb_we", rb_write_enable, 0);
    check("rst_rb_waddr", rb_write_address, 0);
    check("rst_rb_addr_a", rb_address_a, 0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check("rel_req_ready_low", req_ready, 0);
    tick();
    check("rel_req_ready", req_ready, 1);
    check("rel_wb_ready", wb_ready, 1);

    // Writeback then read: reg2 = 0x5A, reg3 untouched
    wb(2'd2, 8'h5A, 1);
    tick();
    wb_valid = 1'b0;
    check("wb_we", rb_write_enable, 1);
    check("wb_waddr", rb_write_address, 2);
    check("wb_wdata", rb_write_data, 8'h5A);
    issue(2'd2, 2'd3);
    tick();
    req_valid = 1'b0;
    check("wb_we_drop", rb_write_enable, 0);
    check("wb_waddr_hold", rb_write_address, 2);
    check("read_req_ready", req_ready, 0);
    check("read_op_valid", op_valid, 0);
    expect_resp("basic", lat);
    check("basic_latency", lat, 1);
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    check("basic_idle_op_valid", op_valid, 0);

    // Bypass: writeback and request accepted on the same edge
    wb(2'd1, 8'hC3, 1);
    issue(2'd1, 2'd1);
    tick();
    wb_valid = 1'b0;
    req_valid = 1'b0;
    expect_resp("bypass", lat);

    // Backpressure: held snapshot survives writes to its source register
    for (int i = 0; i < 5; i++) begin
      wb(2'd1, 8'hFF, 1);
      tick();
      check($sformatf("hold_op_a_%0d", i), op_a, 8'hC3);
      check($sformatf("hold_op_valid_%0d", i), op_valid, 1);
      check($sformatf("hold_req_ready_%0d", i), req_ready, 0);
    end
    wb_valid = 1'b0;
    op_ready = 1'b1;
    tick();
    check("hold_release_op_valid", op_valid, 0);

    // Back-to-back requests, rs_a 0..3 then wrap to 0
    for (int k = 0; k < 5; k++) begin
      issue(2'(k % 4), 2'(3 - (k % 4)));
      tick();
      check($sformatf("b2b_read_%0d", k), op_valid, 0);
      tick();
      check($sformatf("b2b_hold_%0d", k), op_valid, 1);
      expect_resp($sformatf("b2b_%0d", k), lat);
    end
    req_valid = 1'b0;
    tick();
    check("b2b_idle", op_valid, 0);
    op_ready = 1'b0;

    // Reset during READ with a writeback in flight
    issue(2'd2, 2'd0);
    tick();
    wb(2'd0, 8'h11, 0);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("mid_rst_op_valid", op_valid, 0);
    check("mid_rst_req_ready", req_ready, 0);
    check("mid_rst_rb_we", rb_write_enable, 0);
    check("mid_rst_rb_addr_a", rb_address_a, 0);
    tick(); tick();
    wb_valid = 1'b0;
    req_valid = 1'b0;
    check("mid_rst_bank0", bank[0], mdl[0]);
    rst_n = 1'b1;
    tick();
    check("mid_rst_req_ready_back", req_ready, 1);
    issue(2'd0, 2'd2);
    tick();
    req_valid = 1'b0;
    expect_resp("post_rst", lat);
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;

    // Continuous writebacks to the top register
    for (int d = 0; d < 256; d++) begin
      wb(2'd3, 8'(d), 1);
      tick();
      check($sformatf("stream_we_%0d", d), rb_write_enable, 1);
    end
    wb_valid = 1'b0;
    tick();
    check("stream_bank3", bank[3], 8'hFF);
    issue(2'd3, 2'd3);
    tick();
    req_valid = 1'b0;
    expect_resp("stream_read", lat);
    op_ready = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
